mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the CPU dataflow's data/instruction port.
- Accepts one request at a time (address, write data, size, write enable) and services it from an internal word-organised RAM after a programmable number of wait states.
- Returns a one-cycle ack with lane-aligned read data. Read data is right-justified so the CPU's sign/zero extender only needs the size.

Parameters:
- ADDR_W, 12, byte-address width decoded; RAM depth = 2^(ADDR_W-2) words.
- WAIT_CYCLES, 2, extra wait states between accept and access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rs_i  in  1  asynchronous active-low reset.
- req_i  in  1  request strobe; sampled only while ready_o=1.
- we_i  in  1  1 = write, 0 = read.
- size_i  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data, right-justified (byte in [7:0], half in [15:0]).
- ready_o  out  1  responder idle; a request is accepted this cycle if req_i=1.
- ack_o  out  1  one-cycle pulse: request completed.
- rdata_o  out  32  read data, valid only when ack_o=1; holds its value otherwise.
- err_o  out  1  qualifies ack_o: access faulted.

Behaviour:
- Reset (rs_i=0, async): state=IDLE, ready_o=1, ack_o=0, err_o=0, rdata_o=0, wait counter=0. RAM contents are not reset.
- State IDLE:
  - ready_o=1.
  - req_i=1 latches addr/we/size/wdata.
  - Next state is WAIT with count=WAIT_CYCLES-1, or ACCESS directly when WAIT_CYCLES=0.
- State WAIT:
  - ready_o=0; count decrements each cycle.
  - At count=0, next state is ACCESS.
- State ACCESS:
  - Fault check: out of range (addr[31:ADDR_W] != 0) sets fault.
  - Write with no fault: RAM[addr[ADDR_W-1:2]] is updated on the edge leaving ACCESS.
    - Byte: lane addr[1:0].
    - Half: lane addr[1].
    - Word: all 4 lanes.
    - Other lanes are preserved.
  - Read with no fault: rdata_o <= word >> (8*addr[1:0]), upper bits zero-filled by the shift.
  - Fault: no RAM write, rdata_o <= 0, err_o <= 1.
  - Next state is RESP.
- State RESP:
  - ack_o=1 for exactly one cycle; err_o is valid.
  - Next state is IDLE; err_o clears on exit.
- Latency:
  - Request accepted at edge T gives ack_o high in cycle T+WAIT_CYCLES+2.
  - Back-to-back requests are possible: req_i held high in the cycle after ack is accepted from IDLE.
- Requests while ready_o=0 are ignored and not queued.
- Write-then-read to the same address returns the new data; there is no read-before-write hazard because accesses are serialized.
- Reset mid-operation: any in-flight request is dropped with no ack. A write is cancelled unless the ACCESS exit edge has already occurred.
- Inputs are latched at accept; changes to inputs after accept have no effect.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is a fault. The fault behaves as above: no write, rdata 0, err_o=1.
- Undefined: the misaligned low address bits are masked (half: addr[0]=0; word: addr[1:0]=0) before the access. err_o then flags only out-of-range accesses.

Decomposition:
- Shared package (mem_pkg):
  - size encodings MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10.
  - FSM state encoding IDLE/WAIT/ACCESS/RESP.
  - lane-mask function size+offset to 4-bit byte-enable.
- Natural sub-module: mem_ram_be, a single-port synchronous RAM with 4 byte-enables and 2^(ADDR_W-2) words. The responder FSM drives it.

Test Plan:
- Reset, then word write 0xDEADBEEF to 0x010, then word read 0x010 -> ack in cycle T+4 (WAIT_CYCLES=2), rdata_o=0xDEADBEEF, err_o=0.
- Byte write 0x5A to 0x013 over the previous word, then word read 0x010 -> 0x5AADBEEF; byte read 0x013 -> rdata_o=0x0000005A.
- Half read 0x012 from 0x5AADBEEF -> 0x00005AAD. Pulse req_i during WAIT -> no second ack, RAM unchanged.
- Write to 0x0000_2000 (ADDR_W=12) -> ack with err_o=1, rdata_o=0, no RAM lane altered (read back 0x000 unchanged).
- Word read 0x011:
  - with MEM_MISALIGN_TRAP_EN -> err_o=1, rdata_o=0.
  - without it -> err_o=0, data of word 0x010.
- Deassert rs_i during WAIT of a write 0x11111111 to 0x020 -> no ack, ready_o=1 immediately, later read 0x020 returns the prior value. Also run with WAIT_CYCLES=0 and check ack in cycle T+2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: size codes, FSM encoding,
// latched request record and byte-lane helpers.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Lane offset after forcing natural alignment (size 11 behaves as word).
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return off;
            MEM_H:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 4'b0001 << off;
            MEM_H:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU data port (master) and the memory
// responder (slave).
interface mem_responder_if;

    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport slave (
        input  req_i,
        input  we_i,
        input  size_i,
        input  addr_i,
        input  wdata_i,
        output ready_o,
        output ack_o,
        output rdata_o,
        output err_o
    );

    modport master (
        output req_i,
        output we_i,
        output size_i,
        output addr_i,
        output wdata_i,
        input  ready_o,
        input  ack_o,
        input  rdata_o,
        input  err_o
    );

endinterface

// File: rtl/mem_ram_be.sv
// Single-port synchronous RAM, 2^(ADDR_W-2) 32-bit words, four byte enables,
// registered read (old data on read-during-write).
module mem_ram_be #(
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [3:0]          be,
    input  logic [ADDR_W-3:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // One narrow array per lane keeps byte-enable inference trivial.
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                q_reg <= mem[addr];
            end

            assign rdata[8*gi +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one request at a time, WAIT_CYCLES wait states, one-cycle ack.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being masked.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rs_i,
    mem_responder_if.slave bus
);

    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    mem_req_t    req_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic             accept;
    logic [1:0]       eff_off;
    logic             fault;
    logic [IDX_W-1:0] ram_addr;
    logic             ram_we;
    logic [3:0]       ram_be;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;
    logic [31:0]      rd_shifted;

    assign accept  = (state_reg == ST_IDLE) && bus.req_i;
    assign eff_off = lane_offset(req_reg.size, req_reg.addr[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign fault = (|req_reg.addr[31:ADDR_W]) || misaligned(req_reg.size, req_reg.addr[1:0]);
`else
    assign fault = |req_reg.addr[31:ADDR_W];
`endif

    // In IDLE the RAM looks at the live address so the registered read is
    // already valid by the time ACCESS is reached, even with zero wait states.
    assign ram_addr   = (state_reg == ST_IDLE) ? bus.addr_i[ADDR_W-1:2] : req_reg.addr[ADDR_W-1:2];
    assign ram_we     = (state_reg == ST_ACCESS) && req_reg.we && !fault;
    assign ram_be     = lane_mask(req_reg.size, eff_off);
    assign ram_wdata  = req_reg.wdata << {eff_off, 3'b000};
    assign rd_shifted = ram_rdata >> {eff_off, 3'b000};

    mem_ram_be #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.req_i) begin
                    state_next = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                    count_next = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (count_reg == 4'd0) begin
                    state_next = ST_ACCESS;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
            ST_ACCESS: state_next = ST_RESP;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rs_i) begin
        if (!rs_i) begin
            state_reg <= ST_IDLE;
            count_reg <= 4'd0;
            req_reg   <= '0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (accept) begin
                req_reg <= '{we: bus.we_i, size: bus.size_i, addr: bus.addr_i, wdata: bus.wdata_i};
            end
            if (state_reg == ST_ACCESS) begin
                err_reg <= fault;
                if (fault) begin
                    rdata_reg <= 32'd0;
                end else if (!req_reg.we) begin
                    rdata_reg <= rd_shifted;
                end
            end else if (state_reg == ST_RESP) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign bus.ready_o = (state_reg == ST_IDLE);
    assign bus.ack_o   = (state_reg == ST_RESP);
    assign bus.rdata_o = rdata_reg;
    assign bus.err_o   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int W_SLOW = 2;
    localparam int W_FAST = 0;

    logic clk;
    logic rs_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_responder_if bus2();
    mem_responder_if bus0();

    mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W_SLOW)) dut (
        .clk  (clk),
        .rs_i (rs_i),
        .bus  (bus2.slave)
    );

    mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W_FAST)) dut_fast (
        .clk  (clk),
        .rs_i (rs_i),
        .bus  (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit fast, input logic req, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (fast) begin
            bus0.req_i = req; bus0.we_i = we; bus0.size_i = size; bus0.addr_i = addr; bus0.wdata_i = wdata;
        end else begin
            bus2.req_i = req; bus2.we_i = we; bus2.size_i = size; bus2.addr_i = addr; bus2.wdata_i = wdata;
        end
    endtask

    // One full transaction from IDLE; optionally pulses a stray write request during the busy period.
    task automatic xfer(input bit fast, input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input bit chk_rd, input bit glitch);
        int          k;
        int          exp_lat;
        logic        ack_s;
        logic        err_s;
        logic [31:0] rd_s;
        exp_lat = (fast ? W_FAST : W_SLOW) + 1;
        drive(fast, 1'b1, we, size, addr, wdata);
        @(posedge clk); #1;
        drive(fast, 1'b0, we, size, addr, wdata);
        check("busy_after_accept", fast ? bus0.ready_o : bus2.ready_o, 32'd0);
        if (glitch) drive(fast, 1'b1, 1'b1, MEM_W, addr, 32'h0);
        k = 1;
        ack_s = 1'b0;
        while (k <= 20) begin
            @(posedge clk); #1;
            drive(fast, 1'b0, we, size, addr, wdata);
            ack_s = fast ? bus0.ack_o : bus2.ack_o;
            if (ack_s) break;
            k++;
        end
        err_s = fast ? bus0.err_o : bus2.err_o;
        rd_s  = fast ? bus0.rdata_o : bus2.rdata_o;
        $display("[TB] %s %s sz=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b edges=%0d",
                 fast ? "w0" : "w2", we ? "WR" : "RD", size, addr, wdata, rd_s, err_s, k);
        check("ack_latency", 32'(k), 32'(exp_lat));
        check("err", err_s, exp_err);
        if (chk_rd) check("rdata", rd_s, exp_rd);
        @(posedge clk); #1;
        check("ack_one_cycle", fast ? bus0.ack_o : bus2.ack_o, 32'd0);
        check("err_cleared", fast ? bus0.err_o : bus2.err_o, 32'd0);
        if (chk_rd) check("rdata_hold", fast ? bus0.rdata_o : bus2.rdata_o, exp_rd);
    endtask

    initial begin
        int acks;
        rs_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, MEM_W, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus2.ready_o, 32'd1);
        check("rst_ack", bus2.ack_o, 32'd0);
        check("rst_err", bus2.err_o, 32'd0);
        check("rst_rdata", bus2.rdata_o, 32'd0);
        check("rst_ready_w0", bus0.ready_o, 32'd1);
        rs_i = 1'b1;
        @(posedge clk); #1;

        // Word write / read, then byte merge into the same word.
        xfer(1'b0, 1'b1, MEM_W, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, MEM_W, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 1'b1, MEM_B, 32'h013, 32'h0000005A, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, MEM_W, 32'h010, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, MEM_B, 32'h013, 32'h0, 32'h0000005A, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, MEM_H, 32'h012, 32'h0, 32'h00005AAD, 1'b0, 1'b1, 1'b0);

        // Stray request while busy: no second ack, word untouched.
        xfer(1'b0, 1'b0, MEM_W, 32'h010, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1, 1'b1);
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus2.ack_o) acks++;
        end
        check("no_extra_ack", 32'(acks), 32'd0);
        xfer(1'b0, 1'b0, MEM_W, 32'h010, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1, 1'b0);

        // Out-of-range accesses fault and leave word 0 alone.
        xfer(1'b0, 1'b1, MEM_W, 32'h000, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, MEM_W, 32'h000, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 1'b1, MEM_W, 32'h0000_2000, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, MEM_W, 32'h000, 32'h0, 32'h12345678, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, MEM_B, 32'h0000_1010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Misaligned word read.
`ifdef MEM_MISALIGN_TRAP_EN
        xfer(1'b0, 1'b0, MEM_W, 32'h011, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
`else
        xfer(1'b0, 1'b0, MEM_W, 32'h011, 32'h0, 32'h5AADBEEF, 1'b0, 1'b1, 1'b0);
`endif

        // Upper half-word write preserves the low lanes.
        xfer(1'b0, 1'b1, MEM_H, 32'h012, 32'h00001234, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 1'b0, MEM_W, 32'h010, 32'h0, 32'h1234BEEF, 1'b0, 1'b1, 1'b0);

        // Reset during WAIT of a write cancels it.
        xfer(1'b0, 1'b1, MEM_W, 32'h020, 32'hAAAA5555, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, MEM_W, 32'h020, 32'h11111111);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, MEM_W, 32'h020, 32'h11111111);
        @(posedge clk); #1;
        rs_i = 1'b0;
        #1;
        check("midrst_ready", bus2.ready_o, 32'd1);
        check("midrst_ack", bus2.ack_o, 32'd0);
        check("midrst_rdata", bus2.rdata_o, 32'd0);
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus2.ack_o) acks++;
        end
        check("midrst_no_ack", 32'(acks), 32'd0);
        rs_i = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 1'b0, MEM_W, 32'h020, 32'h0, 32'hAAAA5555, 1'b0, 1'b1, 1'b0);

        // Zero wait states.
        xfer(1'b1, 1'b1, MEM_W, 32'h030, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, MEM_W, 32'h030, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
        xfer(1'b1, 1'b0, MEM_B, 32'h031, 32'h0, 32'h00CAFEF0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
